imem_refill_resp: RTL

// - Memory-side responder for the I-cache line-refill handshake (mem_r / mem_ready).
// - Takes a held mem_r plus a byte address and reads one aligned line of LINE_WORDS words from a

---
 rtl/imem_refill_resp_pkg.sv | 21 ++
 rtl/imem_refill_resp_if.sv | 30 +++
 rtl/imem_refill_resp_lat_pipe.sv | 38 +++
 rtl/imem_refill_resp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/imem_refill_resp_pkg.sv
// Shared state encoding and sizing helpers for the I-cache line-refill responder.
package imem_resp_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      READY = 2'd3
   } state_t;

   function automatic int line_w(input int line_words);
      return line_words * WORD_W;
   endfunction

   function automatic int idx_w(input int line_words);
      return $clog2(line_words);
   endfunction

endpackage

// File: rtl/imem_refill_resp_if.sv
// Refill handshake between the I-cache controller (master) and the memory-side responder (slave).
interface imem_refill_resp_if
   import imem_resp_pkg::*;
#(
   parameter int LINE_WORDS = 8
);

   logic                            mem_r;
   logic [31:0]                     mem_addr;
   logic                            buf_flush;
   logic                            mem_ready;
   logic [line_w(LINE_WORDS)-1:0]   mem_rdata;

   modport master (
      output mem_r,
      output mem_addr,
      output buf_flush,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_r,
      input  mem_addr,
      input  buf_flush,
      output mem_ready,
      output mem_rdata
   );

endinterface

// File: rtl/imem_refill_resp_lat_pipe.sv
// RAM_LAT-deep pipe of {valid, word index}; its tail marks the cycle a RAM word is capturable.
module refill_lat_pipe #(
   parameter int RAM_LAT = 1,
   parameter int IDX_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx
);

   logic [RAM_LAT-1:0] vld_r;
   logic [IDX_W-1:0]   idx_r [RAM_LAT];

   // Shift the issued word index alongside the RAM read latency; abort drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_r <= '0;
         for (int k = 0; k < RAM_LAT; k++) begin
            idx_r[k] <= '0;
         end
      end else begin
         vld_r[0] <= in_valid;
         idx_r[0] <= in_idx;
         for (int k = 1; k < RAM_LAT; k++) begin
            vld_r[k] <= vld_r[k-1];
            idx_r[k] <= idx_r[k-1];
         end
      end
   end

   assign out_valid = vld_r[RAM_LAT-1];
   assign out_idx   = idx_r[RAM_LAT-1];

endmodule

// File: rtl/imem_refill_resp.sv
// Memory-side responder: reads one aligned line from a fixed-latency RAM and returns it with a
// single-cycle mem_ready pulse. Define IMEM_LINE_BUF_EN to add a one-entry line buffer.
module imem_refill_resp
   import imem_resp_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int RAM_AW     = 12,
   parameter int RAM_LAT    = 1
) (
   input  logic                clk,
   input  logic                rst,
   imem_refill_resp_if.slave   mem,
   output logic                ram_en,
   output logic [RAM_AW-1:0]   ram_addr,
   input  logic [WORD_W-1:0]   ram_rdata
);

   localparam int IDX_W  = idx_w(LINE_WORDS);
   localparam int LINE_W = line_w(LINE_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   state_t              state_r, state_s;
   logic [IDX_W-1:0]    cnt_r, cnt_s, cnt_inc_s;
   logic [RAM_AW-1:0]   base_r, base_s, req_base_s, word_addr_s;
   logic [RAM_AW-1:0]   ram_addr_r, ram_addr_s;
   logic                ram_en_r, ram_en_s;
   logic                ready_r, ready_s;
   logic                abort_s, start_s, done_s, hit_s;
   logic [LINE_W-1:0]   line_r;
   logic                cap_valid_s;
   logic [IDX_W-1:0]    cap_idx_s;
   logic                unused_addr_s;

   assign word_addr_s   = mem.mem_addr[RAM_AW+1:2];
   assign req_base_s    = {word_addr_s[RAM_AW-1:IDX_W], {IDX_W{1'b0}}};
   assign cnt_inc_s     = cnt_r + IDX_W'(1);
   assign unused_addr_s = ^{mem.mem_addr[31:RAM_AW+2], mem.mem_addr[1:0], word_addr_s[IDX_W-1:0]};

   // Next-state and next registered-output decode for the refill FSM.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      base_s     = base_r;
      ram_en_s   = 1'b0;
      ram_addr_s = ram_addr_r;
      ready_s    = 1'b0;
      abort_s    = 1'b0;
      start_s    = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (mem.mem_r && hit_s) begin
               state_s = READY;
               ready_s = 1'b1;
            end else if (mem.mem_r) begin
               state_s    = ISSUE;
               start_s    = 1'b1;
               base_s     = req_base_s;
               cnt_s      = '0;
               ram_en_s   = 1'b1;
               ram_addr_s = req_base_s;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (!mem.mem_r) begin
               state_s = IDLE;
               abort_s = 1'b1;
            end else if (cnt_r == LAST_IDX) begin
               state_s = DRAIN;
            end else begin
               cnt_s      = cnt_inc_s;
               ram_en_s   = 1'b1;
               ram_addr_s = base_r + {{(RAM_AW-IDX_W){1'b0}}, cnt_inc_s};
            end
         end
         DRAIN: begin
            if (!mem.mem_r) begin
               state_s = IDLE;
               abort_s = 1'b1;
            end else if (cap_valid_s && (cap_idx_s == LAST_IDX)) begin
               state_s = READY;
               ready_s = 1'b1;
               done_s  = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         READY: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state, issue counter and the registered RAM/handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         base_r     <= '0;
         ram_en_r   <= 1'b0;
         ram_addr_r <= '0;
         ready_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         base_r     <= base_s;
         ram_en_r   <= ram_en_s;
         ram_addr_r <= ram_addr_s;
         ready_r    <= ready_s;
      end
   end

   refill_lat_pipe #(
      .RAM_LAT (RAM_LAT),
      .IDX_W   (IDX_W)
   ) u_lat_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort_s),
      .in_valid  (ram_en_r),
      .in_idx    (cnt_r),
      .out_valid (cap_valid_s),
      .out_idx   (cap_idx_s)
   );

   // Line register: each returning word lands in the slot carried by the latency pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_r <= '0;
      end else if (cap_valid_s) begin
         line_r[WORD_W*cap_idx_s +: WORD_W] <= ram_rdata;
      end
   end

`ifdef IMEM_LINE_BUF_EN
   logic              buf_valid_r;
   logic [RAM_AW-1:0] buf_base_r;

   assign hit_s = buf_valid_r && (buf_base_r == req_base_s) && !mem.buf_flush;

   // One-entry line buffer; a fill in progress or aborted leaves line_r untrustworthy.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_r <= 1'b0;
         buf_base_r  <= '0;
      end else if (mem.buf_flush || abort_s || start_s) begin
         buf_valid_r <= 1'b0;
      end else if (done_s) begin
         buf_valid_r <= 1'b1;
         buf_base_r  <= base_r;
      end
   end
`else
   logic unused_flush_s;

   assign hit_s          = 1'b0;
   assign unused_flush_s = mem.buf_flush;
`endif

   assign ram_en        = ram_en_r;
   assign ram_addr      = ram_addr_r;
   assign mem.mem_ready = ready_r;
   assign mem.mem_rdata = line_r;

endmodule
